// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default parameters and packing helper for regfile_mp
package regfile_pkg;
  typedef enum logic {CLEAR, IDLE} clr_state_e;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS = 16;
  localparam int DEF_NRD = 3;
  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write port bundle of regfile_mp
interface regfile_if import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_NREGS),
  parameter int NRD = DEF_NRD
);
  logic CLR;
  logic [NRD*ADDR_W-1:0] RA;
  logic [NRD*DATA_W-1:0] RD;
  logic WEA;
  logic [ADDR_W-1:0] WAA;
  logic [DATA_W-1:0] WDA;
  logic WEB;
  logic [ADDR_W-1:0] WAB;
  logic [DATA_W-1:0] WDB;
  logic [DATA_W-1:0] PC_IN;
  logic READY;
  logic WERR;
  modport master(output CLR, RA, WEA, WAA, WDA, WEB, WAB, WDB, PC_IN, input RD, READY, WERR);
  modport slave(input CLR, RA, WEA, WAA, WDA, WEB, WAB, WDB, PC_IN, output RD, READY, WERR);
endinterface

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: zeroes the array one entry per cycle after reset or CLR, then raises READY
module regfile_clear_fsm import regfile_pkg::*; #(
  parameter int NREGS = DEF_NREGS,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  output logic              READY,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  clr_state_e state;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N || CLR) begin
      state <= CLEAR;
      clr_addr <= '0;
      READY <= 1'b0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == ADDR_W'(NREGS - 1)) begin
        state <= IDLE;
        READY <= 1'b1;
      end
    end
  end
  assign clr_we = state == CLEAR;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / 2-write register file with PC alias and hardware clear.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS = DEF_NREGS,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NRD = DEF_NRD,
  parameter int PC_IDX = NREGS - 1
) (
  input logic      CLK,
  input logic      RST_N,
  regfile_if.slave bus
);
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  logic ready, clr_we, werr, a_ok, b_ok, err;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [NREGS];
  regfile_clear_fsm #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_fsm (
    .CLK(CLK),
    .RST_N(RST_N),
    .CLR(bus.CLR),
    .READY(ready),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  assign a_ok = ready && bus.WEA && bus.WAA != PC_A;
  assign b_ok = ready && bus.WEB && bus.WAB != PC_A;
  assign err = ready && ((bus.WEA && bus.WEB && bus.WAA == bus.WAB) ||
                         (bus.WEA && bus.WAA == PC_A) || (bus.WEB && bus.WAB == PC_A));
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) werr <= 1'b0;
    else if (bus.CLR) werr <= 1'b0;
    else if (err) werr <= 1'b1;
  end
  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (clr_we) mem[clr_addr] <= '0;
    else begin
      if (a_ok) mem[bus.WAA] <= bus.WDA;
      if (b_ok) mem[bus.WAB] <= bus.WDB;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = bus.RA[slice_off(k, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign bus.RD[slice_off(k, DATA_W) +: DATA_W] = !ready ? '0 : a == PC_A ? bus.PC_IN :
      (b_ok && bus.WAB == a) ? bus.WDB : (a_ok && bus.WAA == a) ? bus.WDA : mem[a];
`else
    assign bus.RD[slice_off(k, DATA_W) +: DATA_W] = !ready ? '0 : a == PC_A ? bus.PC_IN : mem[a];
`endif
  end
  assign bus.READY = ready;
  assign bus.WERR = werr;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven bench for regfile_mp (16 x 32, 3 read ports)
module tb_regfile_mp;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;
  regfile_if #(.DATA_W(32), .ADDR_W(4), .NRD(3)) bus ();
  regfile_mp #(.DATA_W(32), .NREGS(16), .ADDR_W(4), .NRD(3), .PC_IDX(15)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );
  typedef struct {
    logic wea; logic [3:0] waa; logic [31:0] wda;
    logic web; logic [3:0] wab; logic [31:0] wdb;
    logic [3:0] ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic ew;
  } vec_t;
  vec_t tbl[6];
  int total = 0;
  int bad = 0;
  int nz = 0;
  int n;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    bus.RA = {a2, a1, a0};
  endtask
  function automatic logic [31:0] rd(input int k);
    return bus.RD[k*32 +: 32];
  endfunction
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.READY && cnt < 64) begin
      @(posedge CLK);
      #1;
      cnt++;
      if (!bus.READY && bus.RD !== '0) nz++;
    end
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'd1, 32'h1111, 1'b1, 4'd2, 32'h2222, 4'd1, 4'd2, 4'd3, 32'h1111, 32'h2222, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd15, 4'd4, 4'd14, 32'h1000, 32'h0, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 4'd4, 32'hA5A5A5A5, 1'b1, 4'd3, 32'h12345678, 4'd4, 4'd3, 4'd0, 32'hA5A5A5A5, 32'h12345678, 32'h0, 1'b0};
    tbl[3] = '{1'b1, 4'd14, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0, 4'd14, 4'd13, 4'd2, 32'hFFFFFFFF, 32'h0, 32'h2222, 1'b0};
    tbl[4] = '{1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 4'd7, 4'd8, 4'd1, 32'h77, 32'h88, 32'h1111, 1'b0};
    tbl[5] = '{1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 4'd5, 4'd4, 4'd3, 32'h22, 32'hA5A5A5A5, 32'h12345678, 1'b1};
    bus.CLR = 1'b0; bus.WEA = 1'b0; bus.WAA = '0; bus.WDA = '0;
    bus.WEB = 1'b0; bus.WAB = '0; bus.WDB = '0; bus.PC_IN = 32'h1000;
    set_ra(4'd15, 4'd3, 4'd0);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.READY), 32'd0);
    chk("rst_werr", 32'(bus.WERR), 32'd0);
    chk("rst_rd_pc", rd(0), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    wait_ready(n);
    chk("rst_ready_cycles", n, 16);
    @(negedge CLK);
    for (int i = 0; i < 15; i++) begin
      set_ra(i[3:0], 4'd0, 4'd0);
      #1;
      chk($sformatf("clr_r%0d", i), rd(0), 32'h0);
    end
    @(negedge CLK);
    bus.WEA = 1'b1; bus.WAA = 4'd3; bus.WDA = 32'hDEADBEEF;
    set_ra(4'd3, 4'd0, 4'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_r3", rd(0), 32'hDEADBEEF);
`else
    chk("same_cycle_r3", rd(0), 32'h0);
`endif
    @(posedge CLK);
    #1 bus.WEA = 1'b0;
    #1 chk("next_cycle_r3", rd(0), 32'hDEADBEEF);
    foreach (tbl[i]) begin
      @(negedge CLK);
      bus.WEA = tbl[i].wea; bus.WAA = tbl[i].waa; bus.WDA = tbl[i].wda;
      bus.WEB = tbl[i].web; bus.WAB = tbl[i].wab; bus.WDB = tbl[i].wdb;
      set_ra(tbl[i].ra0, tbl[i].ra1, tbl[i].ra2);
      @(posedge CLK);
      #1 bus.WEA = 1'b0; bus.WEB = 1'b0;
      @(negedge CLK);
      chk($sformatf("vec%0d_rd0", i), rd(0), tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd(1), tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd(2), tbl[i].e2);
      chk($sformatf("vec%0d_werr", i), 32'(bus.WERR), 32'(tbl[i].ew));
    end
    bus.CLR = 1'b1;
    set_ra(4'd5, 4'd3, 4'd15);
    @(posedge CLK);
    #1 bus.CLR = 1'b0;
    chk("clr_werr", 32'(bus.WERR), 32'd0);
    chk("clr_ready_low", 32'(bus.READY), 32'd0);
    wait_ready(n);
    chk("clr_ready_cycles", n, 16);
    @(negedge CLK);
    chk("clr_r5", rd(0), 32'h0);
    chk("clr_r3", rd(1), 32'h0);
    chk("clr_pc", rd(2), 32'h1000);
    bus.WEB = 1'b1; bus.WAB = 4'd15; bus.WDB = 32'h55;
    set_ra(4'd15, 4'd14, 4'd0);
    @(posedge CLK);
    #1 bus.WEB = 1'b0;
    @(negedge CLK);
    chk("pcw_rd", rd(0), 32'h1000);
    chk("pcw_werr", 32'(bus.WERR), 32'd1);
    bus.PC_IN = 32'h2000;
    #1 chk("pc_follow", rd(0), 32'h2000);
    @(negedge CLK);
    bus.CLR = 1'b1;
    @(posedge CLK);
    #1 bus.CLR = 1'b0;
    bus.WEA = 1'b1; bus.WAA = 4'd2; bus.WDA = 32'h77;
    bus.WEB = 1'b1; bus.WAB = 4'd15; bus.WDB = 32'h99;
    set_ra(4'd2, 4'd15, 4'd0);
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    bus.CLR = 1'b1;
    @(posedge CLK);
    #1 bus.CLR = 1'b0;
    wait_ready(n);
    bus.WEA = 1'b0; bus.WEB = 1'b0;
    chk("midclr_ready_cycles", n, 16);
    chk("midclr_werr", 32'(bus.WERR), 32'd0);
    @(negedge CLK);
    chk("midclr_r2", rd(0), 32'h0);
    bus.WEA = 1'b1; bus.WAA = 4'd6; bus.WDA = 32'h66;
    bus.WEB = 1'b1; bus.WAB = 4'd15; bus.WDB = 32'h1;
    set_ra(4'd6, 4'd6, 4'd15);
    @(posedge CLK);
    #1 bus.WEA = 1'b0; bus.WEB = 1'b0;
    #1 chk("prerst_r6", rd(0), 32'h66);
    chk("prerst_werr", 32'(bus.WERR), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus.READY), 32'd0);
    chk("rst_mid_werr", 32'(bus.WERR), 32'd0);
    chk("rst_mid_rd0", rd(0), 32'h0);
    chk("rst_mid_rd2", rd(2), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    wait_ready(n);
    chk("rerst_ready_cycles", n, 16);
    @(negedge CLK);
    chk("rerst_r6", rd(1), 32'h0);
    chk("rd_zero_not_ready", nz, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
